// File: rtl/zbt_point_loader.sv
// zbt_point_loader
//   Walks the point table (index -> {6'b0, x[9:0], y[9:0], color[9:0]}) and
//   writes each word into ZBT SRAM through the port arbiter, one beat at a
//   time. The ZBT data pipeline itself belongs to the downstream controller.
//
//   Optional feature macro: LOADER_VERIFY_EN
//     When defined, a read-back phase follows the writes. Every address is
//     re-requested as a read (mem_we=0, mem_rd=1). mem_rdata is sampled
//     RD_LAT cycles after each grant and compared with the table word. Any
//     difference sets verify_err, which stays set until the next start or
//     reset. RD_LAT must be at least 1.
//
// Ports
//   clk        system clock, all state on the rising edge
//   reset      asynchronous, active-high reset
//   start      begin a run; only looked at while idle
//   index      table index being fetched
//   value      table word for index (combinational from the table)
//   mem_req    request to the ZBT arbiter
//   mem_gnt    arbiter grant; a beat is accepted on an edge with mem_req&mem_gnt
//   mem_addr   beat address, stable while mem_req
//   mem_we     write enable (equals mem_req outside the read-back phase)
//   mem_wdata  write data, stable while mem_req
//   busy       high in every state except IDLE
//   done       one-cycle pulse when a run completes
//   mem_rdata, mem_rd, verify_err  (LOADER_VERIFY_EN only)
//
// Handshake: mem_req rises with address/data already valid, then holds
// request, address and data unchanged until the edge where mem_gnt is also
// high; mem_gnt while mem_req is low has no effect.

module zbt_point_loader #(
    parameter int                NUM_ENTRIES = 4,
    parameter int                IDX_W       = 2,
    parameter int                ADDR_W      = 19,
    parameter logic [ADDR_W-1:0] BASE_ADDR   = '0
`ifdef LOADER_VERIFY_EN
    ,
    parameter int                RD_LAT      = 2
`endif
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic [IDX_W-1:0]  index,
    input  logic [35:0]       value,
    output logic              mem_req,
    input  logic              mem_gnt,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [35:0]       mem_wdata,
`ifdef LOADER_VERIFY_EN
    input  logic [35:0]       mem_rdata,
    output logic              mem_rd,
    output logic              verify_err,
`endif
    output logic              busy,
    output logic              done
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_ENTRIES - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        REQ    = 3'd2,
        DONE   = 3'd3,
        VFETCH = 3'd4,
        VREQ   = 3'd5,
        VWAIT  = 3'd6
    } state_t;

    state_t state, state_nx;

    logic load;     // capture table word and beat address
    logic idx_inc;
    logic idx_clr;
`ifdef LOADER_VERIFY_EN
    logic       lat_clr;
    logic       cmp;
    logic [7:0] lat_cnt;
`endif

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    // Next state and outputs
    always_comb begin
        state_nx = state;
        load     = 1'b0;
        idx_inc  = 1'b0;
        idx_clr  = 1'b0;
        mem_req  = 1'b0;
        mem_we   = 1'b0;
        done     = 1'b0;
        busy     = (state != IDLE);
`ifdef LOADER_VERIFY_EN
        mem_rd   = 1'b0;
        lat_clr  = 1'b0;
        cmp      = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (start) begin
                    state_nx = FETCH;
                    idx_clr  = 1'b1;
                end
            end
            FETCH: begin
                load     = 1'b1;
                state_nx = REQ;
            end
            REQ: begin
                mem_req = 1'b1;
                mem_we  = 1'b1;
                if (mem_gnt) begin
                    if (index == LAST_IDX) begin
`ifdef LOADER_VERIFY_EN
                        state_nx = VFETCH;
                        idx_clr  = 1'b1;
`else
                        state_nx = DONE;
`endif
                    end else begin
                        idx_inc  = 1'b1;
                        state_nx = FETCH;
                    end
                end
            end
            DONE: begin
                done     = 1'b1;
                idx_clr  = 1'b1;
                state_nx = IDLE;
            end
`ifdef LOADER_VERIFY_EN
            // The table word is reloaded into mem_wdata and used as the
            // expected read value.
            VFETCH: begin
                load     = 1'b1;
                state_nx = VREQ;
            end
            VREQ: begin
                mem_req = 1'b1;
                mem_rd  = 1'b1;
                if (mem_gnt) begin
                    lat_clr  = 1'b1;
                    state_nx = VWAIT;
                end
            end
            VWAIT: begin
                if (lat_cnt == 8'(RD_LAT)) begin
                    cmp = 1'b1;
                    if (index == LAST_IDX) begin
                        state_nx = DONE;
                    end else begin
                        idx_inc  = 1'b1;
                        state_nx = VFETCH;
                    end
                end
            end
`endif
            default: state_nx = IDLE;
        endcase
    end

    // Index and beat registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            index     <= '0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            if (idx_clr)      index <= '0;
            else if (idx_inc) index <= index + IDX_W'(1);
            if (load) begin
                mem_wdata <= value;
                // ADDR_W-bit sum: wraps past the top of the address space
                mem_addr  <= BASE_ADDR + ADDR_W'(index);
            end
        end
    end

`ifdef LOADER_VERIFY_EN
    // Read latency counter: equals k on the k-th edge after the grant edge
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lat_cnt    <= '0;
            verify_err <= 1'b0;
        end else begin
            if (lat_clr)              lat_cnt <= 8'd1;
            else if (state == VWAIT)  lat_cnt <= lat_cnt + 8'd1;
            if (state == IDLE && start)          verify_err <= 1'b0;
            else if (cmp && mem_rdata != mem_wdata) verify_err <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_zbt_point_loader.sv
// Bench for zbt_point_loader (default build). Two instances share stimulus:
// one at base address 0 and one at 19'h7FFFE to exercise address wrap.
module tb_zbt_point_loader;

    localparam int HALF = 5;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        gnt;
    logic [1:0]  idx_a, idx_b;
    logic [35:0] val_a, val_b, wd_a, wd_b;
    logic [18:0] ad_a, ad_b;
    logic        req_a, req_b, we_a, we_b, busy_a, busy_b, done_a, done_b;
    logic [29:0] tbl [4];

    assign val_a = {6'b0, tbl[idx_a]};
    assign val_b = {6'b0, tbl[idx_b]};

    always #HALF clk = ~clk;

    zbt_point_loader #(.BASE_ADDR(19'h00000)) dut_a (
        .clk(clk), .reset(rst), .start(start), .index(idx_a), .value(val_a),
        .mem_req(req_a), .mem_gnt(gnt), .mem_addr(ad_a), .mem_we(we_a),
        .mem_wdata(wd_a), .busy(busy_a), .done(done_a)
    );

    zbt_point_loader #(.BASE_ADDR(19'h7FFFE)) dut_b (
        .clk(clk), .reset(rst), .start(start), .index(idx_b), .value(val_b),
        .mem_req(req_b), .mem_gnt(gnt), .mem_addr(ad_b), .mem_we(we_b),
        .mem_wdata(wd_b), .busy(busy_b), .done(done_b)
    );

    int checks = 0;
    int errors = 0;
    int extra_a = 0;
    int extra_b = 0;
    bit mon_en = 1'b0;
    logic [54:0] exp_qa[$];
    logic [54:0] exp_qb[$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: accepted beats are compared against the expected queues,
    // stalled beats must hold request, address and data.
    logic        p_req = 1'b0, p_gnt = 1'b0;
    logic [18:0] p_ad_a, p_ad_b;
    logic [35:0] p_wd_a, p_wd_b;
    always begin
        @(negedge clk);
        #1;
        if (mon_en) begin
            check("we_eq_req_a", {63'b0, we_a}, {63'b0, req_a});
            check("we_eq_req_b", {63'b0, we_b}, {63'b0, req_b});
            if (p_req && !p_gnt && !rst) begin
                check("hold_req_a", {63'b0, req_a}, 64'd1);
                check("hold_addr_a", {45'b0, ad_a}, {45'b0, p_ad_a});
                check("hold_data_a", {28'b0, wd_a}, {28'b0, p_wd_a});
                check("hold_addr_b", {45'b0, ad_b}, {45'b0, p_ad_b});
                check("hold_data_b", {28'b0, wd_b}, {28'b0, p_wd_b});
            end
            if (req_a && gnt) begin
                if (exp_qa.size() > 0) check("write_a", {9'b0, ad_a, wd_a}, {9'b0, exp_qa.pop_front()});
                else extra_a++;
            end
            if (req_b && gnt) begin
                if (exp_qb.size() > 0) check("write_b", {9'b0, ad_b, wd_b}, {9'b0, exp_qb.pop_front()});
                else extra_b++;
            end
        end
        p_req  = req_a;
        p_gnt  = gnt;
        p_ad_a = ad_a;
        p_wd_a = wd_a;
        p_ad_b = ad_b;
        p_wd_b = wd_b;
    end

    task automatic check_zero_outputs(input string tag);
        check({tag, "_index"}, {62'b0, idx_a}, 64'd0);
        check({tag, "_req"}, {63'b0, req_a}, 64'd0);
        check({tag, "_we"}, {63'b0, we_a}, 64'd0);
        check({tag, "_addr"}, {45'b0, ad_a}, 64'd0);
        check({tag, "_wdata"}, {28'b0, wd_a}, 64'd0);
        check({tag, "_busy"}, {63'b0, busy_a}, 64'd0);
        check({tag, "_done"}, {63'b0, done_a}, 64'd0);
        check({tag, "_addr_b"}, {45'b0, ad_b}, 64'd0);
        check({tag, "_req_b"}, {63'b0, req_b}, 64'd0);
    endtask

    // One run (or two back-to-back with start held high).
    //   st_idx/st_len : hold mem_gnt low for st_len cycles during that entry's request
    //   sp_at         : extra start pulse in that cycle (0 = none)
    //   hold          : keep start high so a second run follows
    //   rst_idx       : assert reset during that entry's request (-1 = none)
    task automatic run(input int st_idx, input int st_len, input int sp_at,
                       input bit hold, input int rst_idx);
        int stalled = 0;
        int d1, d2, last;
        bit exp_done, exp_busy;
        logic [18:0] a_b;
        extra_a = 0;
        extra_b = 0;
        for (int r = 0; r < (hold ? 2 : 1); r++) begin
            for (int i = 0; i < 4; i++) begin
                a_b = 19'h7FFFE + 19'(i);
                exp_qa.push_back({19'(i), 6'b0, tbl[i]});
                exp_qb.push_back({a_b, 6'b0, tbl[i]});
            end
        end
        // Two cycles per entry (fetch + request), plus done, plus stall cycles;
        // a held start restarts one idle cycle after done.
        d1   = 9 + st_len;
        d2   = hold ? d1 + 10 : -1;
        last = hold ? d2 : d1;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        for (int k = 1; k <= last + 2; k++) begin
            @(negedge clk);
            if (!hold && k == 1) start = 1'b0;
            if (hold && k == d1 + 2) start = 1'b0;
            if (sp_at > 0 && k == sp_at) start = 1'b1;
            if (sp_at > 0 && k == sp_at + 1) start = 1'b0;
            if (rst_idx >= 0 && req_a && idx_a == 2'(rst_idx)) begin
                gnt = 1'b0;
                rst = 1'b1;
                #1;
                check_zero_outputs("midrun_reset");
                check("midrun_pending_a", 64'(exp_qa.size()), 64'(4 - rst_idx));
                exp_qa.delete();
                exp_qb.delete();
                @(negedge clk);
                rst = 1'b0;
                gnt = 1'b1;
                start = 1'b0;
                return;
            end
            if (st_len > 0 && req_a && idx_a == 2'(st_idx) && stalled < st_len) begin
                gnt = 1'b0;
                stalled++;
            end else begin
                gnt = 1'b1;
            end
            exp_done = (k == d1) || (k == d2);
            exp_busy = (k <= d1) || (hold && k >= d1 + 2 && k <= d2);
            check("done_a", {63'b0, done_a}, {63'b0, exp_done});
            check("done_b", {63'b0, done_b}, {63'b0, exp_done});
            check("busy_a", {63'b0, busy_a}, {63'b0, exp_busy});
            check("busy_b", {63'b0, busy_b}, {63'b0, exp_busy});
        end
        check("writes_missing_a", 64'(exp_qa.size()), 64'd0);
        check("writes_missing_b", 64'(exp_qb.size()), 64'd0);
        check("writes_extra_a", 64'(extra_a), 64'd0);
        check("writes_extra_b", 64'(extra_b), 64'd0);
        exp_qa.delete();
        exp_qb.delete();
    endtask

    task automatic random_table();
        for (int i = 0; i < 4; i++) tbl[i] = 30'($urandom);
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        gnt   = 1'b1;
        tbl[0] = {10'd300, 10'd300, 10'h3FC};
        tbl[1] = {10'd300, 10'd300, 10'h0FC};
        tbl[2] = {10'd500, 10'd500, 10'h0FC};
        tbl[3] = {10'd400, 10'd400, 10'h1FC};
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        check_zero_outputs("reset");
        @(negedge clk);
        rst    = 1'b0;
        mon_en = 1'b1;

        // Plain run, grant always high
        run(0, 0, 0, 1'b0, -1);
        // Grant withheld 5 cycles on entry 1
        run(1, 5, 0, 1'b0, -1);
        // Start pulse while busy is ignored
        run(0, 0, 4, 1'b0, -1);
        // Reset during the request of entry 2, then a fresh full run
        random_table();
        run(0, 0, 0, 1'b0, 2);
        run(0, 0, 0, 1'b0, -1);
        // Start held high: a second run follows the first done
        random_table();
        run(0, 0, 0, 1'b1, -1);

        // Randomized runs
        for (int n = 0; n < 8; n++) begin
            random_table();
            run(int'($urandom_range(0, 3)), int'($urandom_range(0, 6)),
                int'($urandom_range(0, 8)), 1'b0, -1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/zbt_point_loader.md
Name: zbt_point_loader

Overview:
- Sequencer that walks the 4-entry point table (index → 36-bit word {6'b0, x[9:0], y[9:0], color[9:0]}) and writes each word into ZBT SRAM.
- Sits between the point table and the ZBT port arbiter.
- Drives the table's 2-bit index, registers the returned word and presents one write at a time to the arbiter with a req/gnt handshake.
- The downstream ZBT controller handles the two-cycle ZBT data pipeline; this block only issues address/data/we per granted beat.

Parameters:
NUM_ENTRIES, 4, number of table entries written per run (1..2^IDX_W)
IDX_W, 2, width of index port
ADDR_W, 19, ZBT address width
BASE_ADDR, 19'd0, ZBT address of entry 0; entry i is written at BASE_ADDR+i (wraps modulo 2^ADDR_W)

Ports:
clk  in  1  system clock, all state on rising edge
reset  in  1  asynchronous, active-high reset
start  in  1  begin a run; sampled only in IDLE
index  out  IDX_W  table index being fetched
value  in  36  table word for index (combinational, valid same cycle)
mem_req  out  1  write request to ZBT arbiter
mem_gnt  in  1  arbiter grant; write accepted on edge where mem_req&mem_gnt
mem_addr  out  ADDR_W  write address, stable while mem_req
mem_we  out  1  write enable, equals mem_req
mem_wdata  out  36  write data, stable while mem_req
busy  out  1  high in any state other than IDLE
done  out  1  one-cycle pulse when run completes

Behaviour:
- Reset (async): state=IDLE, index=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, busy=0, done=0; no write is issued after reset asserts, partial runs are abandoned.
- States: IDLE, FETCH, REQ, DONE.
- IDLE: start=1 → FETCH, index=0. start=0 → stay.
- FETCH (1 cycle): index stable; at edge register mem_wdata<=value, mem_addr<=BASE_ADDR+index → REQ.
- REQ: mem_req=mem_we=1; addr/data held stable until grant. On edge with mem_gnt=1: if index==NUM_ENTRIES-1 → DONE, else index<=index+1 → FETCH. mem_gnt=0 → stay (no timeout).
- mem_req never deasserts before grant; mem_gnt while mem_req=0 ignored.
- DONE (1 cycle): done=1, busy=1 → IDLE, index<=0.
- start while busy ignored (not queued); start held high in IDLE after DONE starts a new run.
- Latency with mem_gnt tied high: start sampled at edge 0; writes granted at end of cycles 2,4,6,8; done high in cycle 9; busy high cycles 1–9.
- Address arithmetic: ADDR_W-bit unsigned, overflow wraps, no error.

Optional Feature:
- Macro LOADER_VERIFY_EN.
- Defined:
  - Adds param RD_LAT (default 2), ports mem_rdata in 36, mem_rd out 1, verify_err out 1 (reset 0).
  - After the last write, a VERIFY phase reissues each address with mem_req=1, mem_we=0, mem_rd=1 under the same handshake.
  - Captures mem_rdata RD_LAT cycles after each grant and compares it to the table value.
  - Any mismatch sets verify_err sticky until the next start or reset.
  - done fires after the last compare.
- Undefined: no extra ports, mem_we==mem_req always, timing as above.

Test Plan:
- Reset, mem_gnt=1, pulse start → writes at addr 0..3 with data {0,300,300,10'h3FC},{0,300,300,10'h0FC},{0,500,500,10'h0FC},{0,400,400,10'h1FC}; done in cycle 9.
- mem_gnt low 5 cycles during entry 1 REQ → mem_req/addr/data held constant for those cycles, no extra writes, done delayed by 5 cycles.
- start pulsed during cycle 4 of a run → ignored, exactly 4 writes, single done pulse.
- reset asserted mid-REQ of entry 2 → all outputs 0 immediately; next start rewrites from entry 0.
- BASE_ADDR=19'h7FFFE → addresses 7FFFE, 7FFFF, 00000, 00001.
- LOADER_VERIFY_EN, memory model corrupting addr 2 → verify_err=1 at done; clean model → verify_err=0.
